// File: rtl/program_sequencer_stack.sv
// Program sequencer: computes the next program-memory address each cycle and
// registers it as pc. It keeps a hardware return-address stack for call/ret,
// supports stall and soft reset, and keeps sticky overflow/underflow flags.
// Optional macro PS_STACK_TRAP_EN: a stack fault vectors to TRAP_ADDR instead.
module program_sequencer_stack #(
  parameter int              ADDR_W      = 8,
  parameter int              JMP_W       = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'('hF0),
  localparam int             SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_reset,
  input  logic              stall,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic              dont_jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [JMP_W-1:0]  jmp_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_ovf,
  output logic              stack_udf
);

  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] pm_d;
  logic              push;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] top_entry;
  logic [ADDR_W-1:0] udf_addr;
  logic [ADDR_W-1:0] ovf_addr;
  logic              full;
  logic              empty;

  // Sequential increment wraps naturally at the address width.
  assign pc_inc = pc_q + ADDR_W'(1);
  // Jump field selects the top bits of the address; the low bits are zero.
  assign target = {jmp_addr, {(ADDR_W - JMP_W){1'b0}}};
  assign full   = (sp_q == SP_W'(STACK_DEPTH));
  assign empty  = (sp_q == '0);

`ifdef PS_STACK_TRAP_EN
  assign udf_addr = TRAP_ADDR;
  assign ovf_addr = TRAP_ADDR;
`else
  assign udf_addr = pc_inc;
  assign ovf_addr = target;
  logic unused_trap;
  assign unused_trap = ^TRAP_ADDR;
`endif

  // Read the most recently pushed entry (index sp-1); zero when empty.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top_entry = stack_q[i];
    end
  end

  // Next-address priority: sync_reset, stall, ret, call, jmp, conditional jmp.
  always_comb begin
    pm_d  = pc_inc;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (sync_reset) begin
      pm_d  = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (stall) begin
      pm_d = pc_q;
    end else if (ret) begin
      // ret wins over a simultaneous call; the call is dropped silently.
      if (!empty) begin
        pm_d = top_entry;
        sp_d = sp_q - SP_W'(1);
      end else begin
        pm_d  = udf_addr;
        udf_d = 1'b1;
      end
    end else if (call) begin
      if (!full) begin
        pm_d = target;
        push = 1'b1;
        sp_d = sp_q + SP_W'(1);
      end else begin
        // Push is lost but control flow still leaves.
        pm_d  = ovf_addr;
        ovf_d = 1'b1;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_d = target;
    end
  end

  // Asynchronous reset forces the address bus to zero without waiting for a clock.
  assign pm_addr = reset_n ? pm_d : '0;

  // State update: pc follows pm_addr every edge; push writes the slot at sp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pm_addr;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && (sp_q == SP_W'(i))) stack_q[i] <= pc_inc;
      end
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_ovf   = ovf_q;
  assign stack_udf   = udf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed testbench for program_sequencer_stack: default 8-bit instance plus a
// 12-bit address instance sharing the same strobes.
module tb_program_sequencer_stack;

  logic       clk = 1'b0;
  logic       reset_n, sync_reset, stall, jmp, jmp_nz, dont_jmp, call, ret;
  logic [3:0] jmp_addr;

  logic [7:0]  pm_addr, pc;
  logic [2:0]  sp;
  logic        stack_full, stack_empty, stack_ovf, stack_udf;
  logic [11:0] pm12, pc12;
  logic [2:0]  sp12;
  logic        full12, empty12, ovf12, udf12;

  int n_vec = 0;
  int n_err = 0;

`ifdef PS_STACK_TRAP_EN
  localparam logic [7:0] EXP_UDF = 8'hF0;
  localparam logic [7:0] EXP_OVF = 8'hF0;
`else
  localparam logic [7:0] EXP_UDF = 8'h11;
  localparam logic [7:0] EXP_OVF = 8'h50;
`endif

  always #5 clk = ~clk;

  program_sequencer_stack dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .stall(stall),
    .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret),
    .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_ovf(stack_ovf), .stack_udf(stack_udf)
  );

  program_sequencer_stack #(.ADDR_W(12), .JMP_W(4), .STACK_DEPTH(4)) dut12 (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .stall(stall),
    .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret),
    .jmp_addr(jmp_addr), .pm_addr(pm12), .pc(pc12), .sp(sp12),
    .stack_full(full12), .stack_empty(empty12),
    .stack_ovf(ovf12), .stack_udf(udf12)
  );

  // Advance idle cycles until pc reaches a, bounded.
  task automatic run_to(input logic [7:0] a);
    for (int k = 0; k < 300 && pc !== a; k++) @(negedge clk);
    n_vec++; if (pc !== a) begin n_err++; $display("FAIL run_to: pc=%h wanted %h", pc, a); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sync_reset = 0; stall = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0;
    call = 0; ret = 0; jmp_addr = 4'h0;
    repeat (3) begin
      @(negedge clk);
      n_vec++; if (pm_addr !== 8'h00) begin n_err++; $display("FAIL rst_pm: got %h want 00", pm_addr); end
      n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", pc); end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      n_vec++; if (pc !== 8'(i)) begin n_err++; $display("FAIL rel_pc%0d: got %h want %h", i, pc, 8'(i)); end
    end
    n_vec++; if (sp !== 3'd0) begin n_err++; $display("FAIL rst_sp: got %0d want 0", sp); end
    n_vec++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_err++; $display("FAIL rst_empty: empty=%b full=%b want 1/0", stack_empty, stack_full); end
    n_vec++; if (stack_ovf !== 1'b0 || stack_udf !== 1'b0) begin n_err++; $display("FAIL rst_flags: ovf=%b udf=%b want 0/0", stack_ovf, stack_udf); end
    n_vec++; if (pc12 !== 12'h003) begin n_err++; $display("FAIL rst_pc12: got %h want 003", pc12); end
  endtask

  task automatic test_call_ret();
    run_to(8'h05);
    jmp_addr = 4'h3; call = 1'b1; #1;
    n_vec++; if (pm_addr !== 8'h30) begin n_err++; $display("FAIL call_pm: got %h want 30", pm_addr); end
    @(negedge clk); call = 1'b0;
    n_vec++; if (pc !== 8'h30) begin n_err++; $display("FAIL call_pc: got %h want 30", pc); end
    n_vec++; if (sp !== 3'd1 || stack_empty !== 1'b0) begin n_err++; $display("FAIL call_sp: sp=%0d empty=%b want 1/0", sp, stack_empty); end
    @(negedge clk); @(negedge clk);
    n_vec++; if (pc !== 8'h32) begin n_err++; $display("FAIL run_pc: got %h want 32", pc); end
    ret = 1'b1; #1;
    n_vec++; if (pm_addr !== 8'h06) begin n_err++; $display("FAIL ret_pm: got %h want 06", pm_addr); end
    @(negedge clk); ret = 1'b0;
    n_vec++; if (pc !== 8'h06) begin n_err++; $display("FAIL ret_pc: got %h want 06", pc); end
    n_vec++; if (sp !== 3'd0 || stack_empty !== 1'b1) begin n_err++; $display("FAIL ret_sp: sp=%0d empty=%b want 0/1", sp, stack_empty); end
  endtask

  task automatic test_underflow();
    run_to(8'h10);
    ret = 1'b1; #1;
    n_vec++; if (pm_addr !== EXP_UDF) begin n_err++; $display("FAIL udf_pm: got %h want %h", pm_addr, EXP_UDF); end
    n_vec++; if (stack_udf !== 1'b0) begin n_err++; $display("FAIL udf_early: got %b want 0", stack_udf); end
    @(negedge clk); ret = 1'b0;
    n_vec++; if (stack_udf !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b want 1", stack_udf); end
    n_vec++; if (sp !== 3'd0 || pc !== EXP_UDF) begin n_err++; $display("FAIL udf_state: sp=%0d pc=%h want 0/%h", sp, pc, EXP_UDF); end
    @(negedge clk);
    n_vec++; if (stack_udf !== 1'b1) begin n_err++; $display("FAIL udf_sticky: got %b want 1", stack_udf); end
    sync_reset = 1'b1; #1;
    n_vec++; if (pm_addr !== 8'h00) begin n_err++; $display("FAIL srst_pm: got %h want 00", pm_addr); end
    @(negedge clk); sync_reset = 1'b0;
    n_vec++; if (stack_udf !== 1'b0 || pc !== 8'h00) begin n_err++; $display("FAIL srst_udf: udf=%b pc=%h want 0/00", stack_udf, pc); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) begin
      jmp_addr = 4'(i); call = 1'b1; #1;
      exp = (i == 5) ? EXP_OVF : {4'(i), 4'h0};
      n_vec++; if (pm_addr !== exp) begin n_err++; $display("FAIL ovf_call%0d: got %h want %h", i, pm_addr, exp); end
      @(negedge clk);
      if (i == 4) begin
        n_vec++; if (stack_full !== 1'b1 || stack_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_full4: full=%b ovf=%b want 1/0", stack_full, stack_ovf); end
      end
    end
    call = 1'b0;
    n_vec++; if (sp !== 3'd4 || stack_full !== 1'b1) begin n_err++; $display("FAIL ovf_sp: sp=%0d full=%b want 4/1", sp, stack_full); end
    n_vec++; if (stack_ovf !== 1'b1 || pc !== EXP_OVF) begin n_err++; $display("FAIL ovf_flag: ovf=%b pc=%h want 1/%h", stack_ovf, pc, EXP_OVF); end
    for (int i = 3; i >= 0; i--) begin
      ret = 1'b1; #1;
      exp = {4'(i), 4'h1};
      n_vec++; if (pm_addr !== exp) begin n_err++; $display("FAIL pop%0d: got %h want %h", i, pm_addr, exp); end
      @(negedge clk);
    end
    ret = 1'b0;
    n_vec++; if (sp !== 3'd0 || stack_empty !== 1'b1 || stack_ovf !== 1'b1) begin n_err++; $display("FAIL unwind: sp=%0d empty=%b ovf=%b want 0/1/1", sp, stack_empty, stack_ovf); end
    sync_reset = 1'b1; @(negedge clk); sync_reset = 1'b0;
    n_vec++; if (stack_ovf !== 1'b0 || pc !== 8'h00) begin n_err++; $display("FAIL ovf_clear: ovf=%b pc=%h want 0/00", stack_ovf, pc); end
  endtask

  task automatic test_priority();
    run_to(8'h07);
    stall = 1'b1; call = 1'b1; jmp_addr = 4'h9; #1;
    n_vec++; if (pm_addr !== 8'h07) begin n_err++; $display("FAIL stall_pm: got %h want 07", pm_addr); end
    @(negedge clk); stall = 1'b0; call = 1'b0;
    n_vec++; if (pc !== 8'h07 || sp !== 3'd0) begin n_err++; $display("FAIL stall_state: pc=%h sp=%0d want 07/0", pc, sp); end
    jmp = 1'b1; jmp_addr = 4'h2; @(negedge clk); jmp = 1'b0;
    @(negedge clk);
    n_vec++; if (pc !== 8'h21) begin n_err++; $display("FAIL jmp_pc: got %h want 21", pc); end
    call = 1'b1; jmp_addr = 4'h6; @(negedge clk); call = 1'b0;
    n_vec++; if (pc !== 8'h60 || sp !== 3'd1) begin n_err++; $display("FAIL push22: pc=%h sp=%0d want 60/1", pc, sp); end
    call = 1'b1; ret = 1'b1; jmp_addr = 4'h7; #1;
    n_vec++; if (pm_addr !== 8'h22) begin n_err++; $display("FAIL callret_pm: got %h want 22", pm_addr); end
    @(negedge clk); call = 1'b0; ret = 1'b0;
    n_vec++; if (sp !== 3'd0 || pc !== 8'h22 || stack_ovf !== 1'b0) begin n_err++; $display("FAIL callret_state: sp=%0d pc=%h ovf=%b want 0/22/0", sp, pc, stack_ovf); end
    jmp = 1'b1; jmp_addr = 4'h0; @(negedge clk); jmp = 1'b0;
    run_to(8'h0A);
    jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h5; #1;
    n_vec++; if (pm_addr !== 8'h0B) begin n_err++; $display("FAIL nz_suppress: got %h want 0B", pm_addr); end
    dont_jmp = 1'b0; #1;
    n_vec++; if (pm_addr !== 8'h50) begin n_err++; $display("FAIL nz_taken: got %h want 50", pm_addr); end
    jmp = 1'b1; #1;
    n_vec++; if (pm_addr !== 8'h50) begin n_err++; $display("FAIL jmp_and_nz: got %h want 50", pm_addr); end
    @(negedge clk); jmp = 1'b0; jmp_nz = 1'b0;
    n_vec++; if (pc !== 8'h50) begin n_err++; $display("FAIL nz_pc: got %h want 50", pc); end
  endtask

  task automatic test_wrap();
    jmp = 1'b1; jmp_addr = 4'hF; @(negedge clk); jmp = 1'b0;
    run_to(8'hFF);
    #1;
    n_vec++; if (pm_addr !== 8'h00) begin n_err++; $display("FAIL wrap_pm: got %h want 00", pm_addr); end
    call = 1'b1; jmp_addr = 4'h1; #1;
    n_vec++; if (pm_addr !== 8'h10) begin n_err++; $display("FAIL wrap_call: got %h want 10", pm_addr); end
    @(negedge clk); call = 1'b0;
    n_vec++; if (sp !== 3'd1) begin n_err++; $display("FAIL wrap_sp: got %0d want 1", sp); end
    ret = 1'b1; #1;
    n_vec++; if (pm_addr !== 8'h00) begin n_err++; $display("FAIL wrap_ret: got %h want 00", pm_addr); end
    @(negedge clk); ret = 1'b0;
    n_vec++; if (pc !== 8'h00 || sp !== 3'd0) begin n_err++; $display("FAIL wrap_state: pc=%h sp=%0d want 00/0", pc, sp); end
  endtask

  task automatic test_param12();
    sync_reset = 1'b1; @(negedge clk); sync_reset = 1'b0;
    n_vec++; if (pc12 !== 12'h000 || sp12 !== 3'd0) begin n_err++; $display("FAIL p12_srst: pc=%h sp=%0d want 000/0", pc12, sp12); end
    run_to(8'h05);
    jmp_addr = 4'hA; call = 1'b1; #1;
    n_vec++; if (pm12 !== 12'hA00) begin n_err++; $display("FAIL p12_call_pm: got %h want A00", pm12); end
    n_vec++; if (pm_addr !== 8'hA0) begin n_err++; $display("FAIL p8_call_pm: got %h want A0", pm_addr); end
    @(negedge clk); call = 1'b0;
    n_vec++; if (pc12 !== 12'hA00 || sp12 !== 3'd1) begin n_err++; $display("FAIL p12_call: pc=%h sp=%0d want A00/1", pc12, sp12); end
    @(negedge clk); @(negedge clk);
    n_vec++; if (pc12 !== 12'hA02) begin n_err++; $display("FAIL p12_run: got %h want A02", pc12); end
    ret = 1'b1; #1;
    n_vec++; if (pm12 !== 12'h006) begin n_err++; $display("FAIL p12_ret_pm: got %h want 006", pm12); end
    @(negedge clk); ret = 1'b0;
    n_vec++; if (pc12 !== 12'h006 || sp12 !== 3'd0) begin n_err++; $display("FAIL p12_ret: pc=%h sp=%0d want 006/0", pc12, sp12); end
  endtask

  task automatic test_async_reset();
    call = 1'b1; jmp_addr = 4'h4; @(negedge clk); call = 1'b0;
    #2 reset_n = 1'b0; #1;
    n_vec++; if (pc !== 8'h00 || sp !== 3'd0 || pm_addr !== 8'h00) begin n_err++; $display("FAIL arst: pc=%h sp=%0d pm=%h want 00/0/00", pc, sp, pm_addr); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_call_ret();
    test_underflow();
    test_overflow();
    test_priority();
    test_wrap();
    test_param12();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
